// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder
// Purpose  : Multi-cycle adder/subtractor. Adds (a + b + cin) or subtracts
//            (a - b, as a + ~b + 1) two WIDTH-bit operands CHUNK bits per
//            clock, rippling the carry between chunks through a register so
//            that no full-width carry chain exists in one cycle.
//            N = WIDTH/CHUNK cycles per operation, no overlap of operations.
// Ports    : clk, rstn       - clock (rising edge), synchronous active-low reset
//            in_valid/in_ready   - request handshake (in_ready only in IDLE)
//            a, b, cin, sub      - operands and mode, sampled at the handshake
//            out_valid/out_ready - result handshake
//            sum, cout, ovf      - result, carry out of MSB, signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_N  = WIDTH / CHUNK;
  localparam int c_KW = (c_N > 1) ? $clog2(c_N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;        // already inverted for subtract
  logic             r_carry;
  logic [c_KW-1:0]  r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum_chunk;
  logic             w_carry_out;
  logic             w_last;
  logic             w_carry_into_msb;

  // Select the operand chunk addressed by k (mux over constant slices).
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int i = 0; i < c_N; i++) begin
      if (r_k == c_KW'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  assign {w_carry_out, w_sum_chunk} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                                      + {{CHUNK{1'b0}}, r_carry};
  assign w_last = (r_k == c_KW'(c_N - 1));

  // In the top chunk the carry into the MSB is recovered from the MSB sum bit:
  // s = a ^ b ^ c  =>  c = a ^ b ^ s.
  assign w_carry_into_msb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum_chunk[CHUNK-1];

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < c_N; i++) begin
            if (r_k == c_KW'(i)) r_sum[i*CHUNK +: CHUNK] <= w_sum_chunk;
          end
          r_carry <= w_carry_out;
          if (w_last) begin
            r_k    <= '0;
            r_cout <= w_carry_out;
            r_ovf  <= w_carry_into_msb ^ w_carry_out;
          end else begin
            r_k <= r_k + c_KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_adder
// Purpose  : Directed testbench for chunked_adder. One instance with CHUNK=8
//            (N=4) and one with CHUNK=32 (N=1), sharing clock, reset and
//            operand inputs, each with its own handshake signals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] a, b;
  logic        cin, sub;

  logic        iv8, ir8, ov8, or8, co8, of8;
  logic [31:0] s8;
  logic        iv32, ir32, ov32, or32, co32, of32;
  logic [31:0] s32;

  logic        sel;   // 0: CHUNK=8 instance, 1: CHUNK=32 instance
  wire         ov  = sel ? ov32 : ov8;
  wire  [31:0] sm  = sel ? s32  : s8;
  wire         co  = sel ? co32 : co8;
  wire         of  = sel ? of32 : of8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(iv8), .in_ready(ir8),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );

  chunked_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(iv32), .in_ready(ir32),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32)
  );

  // Drives one request starting at the current negedge, waits (bounded) for
  // the result, completes the result handshake and returns at the negedge
  // after the handshake edge. lat counts edges from accept to out_valid.
  task automatic do_op(input logic w, input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic isub,
                       output logic [31:0] rs, output logic rc, output logic ro,
                       output int lat);
    sel = w; a = ia; b = ib; cin = icin; sub = isub;
    if (w) iv32 = 1'b1; else iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; iv32 = 1'b0;
    lat = 0;
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = sm; rc = co; ro = of;
    if (w) or32 = 1'b1; else or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0; or32 = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; iv8 = 0; iv32 = 0; or8 = 0; or32 = 0;
    a = '0; b = '0; cin = 0; sub = 0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", ir8); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", ov8); end
    checks++; if ({s8, co8, of8} !== 34'h0) begin errors++; $display("FAIL reset sum/cout/ovf: got %h %b %b expected 0 0 0", s8, co8, of8); end
  endtask

  task automatic test_add;
    logic [31:0] s; logic c, o; int lat;
    do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, s, c, o, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_wrap latency: got %0d expected 4", lat); end
    checks++; if ({s, c, o} !== {32'h00000000, 1'b1, 1'b0}) begin errors++; $display("FAIL add_wrap: got %h c=%b v=%b expected 00000000 c=1 v=0", s, c, o); end
    do_op(1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h80000000, 1'b0, 1'b1}) begin errors++; $display("FAIL add_ovf: got %h c=%b v=%b expected 80000000 c=0 v=1", s, c, o); end
    do_op(1'b0, 32'h12345678, 32'h11111111, 1'b1, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h2345678A, 1'b0, 1'b0}) begin errors++; $display("FAIL add_cin: got %h c=%b v=%b expected 2345678a c=0 v=0", s, c, o); end
  endtask

  task automatic test_sub;
    logic [31:0] s; logic c, o; int lat;
    do_op(1'b0, 32'd5, 32'd7, 1'b1, 1'b1, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_borrow: got %h c=%b v=%b expected fffffffe c=0 v=0", s, c, o); end
    do_op(1'b0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin errors++; $display("FAIL sub_ovf: got %h c=%b v=%b expected 7fffffff c=1 v=1", s, c, o); end
  endtask

  task automatic test_backpressure;
    logic [31:0] s; logic c, o; int lat;
    sel = 0; a = 32'h10; b = 32'h20; cin = 0; sub = 0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp latency: got %0d expected 4", lat); end
    for (int i = 0; i < 3; i++) begin
      a = 32'h1000 + i; b = 32'h5; iv8 = 1'b1;   // must be ignored in DONE
      @(negedge clk);
      checks++; if ({ov8, ir8} !== 2'b10) begin errors++; $display("FAIL bp valid/ready cycle %0d: got %b%b expected 10", i, ov8, ir8); end
      checks++; if ({s8, co8, of8} !== {32'h30, 1'b0, 1'b0}) begin errors++; $display("FAIL bp hold cycle %0d: got %h %b %b expected 00000030 0 0", i, s8, co8, of8); end
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    checks++; if ({ov8, ir8} !== 2'b01) begin errors++; $display("FAIL bp release: got valid=%b ready=%b expected 0 1", ov8, ir8); end
    do_op(1'b0, 32'h00000100, 32'h00000001, 1'b0, 1'b1, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h000000FF, 1'b1, 1'b0}) begin errors++; $display("FAIL bp next op: got %h c=%b v=%b expected 000000ff c=1 v=0", s, c, o); end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] s; logic c, o; int lat; int seen;
    sel = 0; a = 32'hFFFFFFFF; b = 32'h0; cin = 0; sub = 0; iv8 = 1'b1;
    @(posedge clk);            // accept, k=0
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk); // chunks 0 and 1 written, k=2
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++; if ({ov8, ir8} !== 2'b01) begin errors++; $display("FAIL mid_reset valid/ready: got %b%b expected 01", ov8, ir8); end
    checks++; if ({s8, co8, of8} !== 34'h0) begin errors++; $display("FAIL mid_reset outputs: got %h %b %b expected 0 0 0", s8, co8, of8); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset aborted result: got %0d valid cycles expected 0", seen); end
    do_op(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h00010000, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_reset next op: got %h c=%b v=%b expected 00010000 c=0 v=0", s, c, o); end
  endtask

  task automatic test_single_chunk;
    logic [31:0] s; logic c, o; int lat;
    do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, s, c, o, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL n1 latency: got %0d expected 1", lat); end
    checks++; if ({s, c, o} !== {32'hFFFFFFFF, 1'b1, 1'b0}) begin errors++; $display("FAIL n1 add: got %h c=%b v=%b expected ffffffff c=1 v=0", s, c, o); end
    do_op(1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, s, c, o, lat);
    checks++; if ({s, c, o} !== {32'h7FFFFFFF, 1'b1, 1'b1}) begin errors++; $display("FAIL n1 sub_ovf: got %h c=%b v=%b expected 7fffffff c=1 v=1", s, c, o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_single_chunk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor, successor to the 1-bit combinational full adder. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a register. It sits behind a valid/ready request channel and a valid/ready result channel. It is built for datapaths where a full-width single-cycle carry chain does not meet timing.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK cycles per operation; CHUNK == WIDTH is legal.
- clk  input  1  clock, all logic on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  operand A, sampled at the request handshake.
- b  input  WIDTH  operand B, sampled at the request handshake.
- cin  input  1  carry-in for add, sampled at the request handshake; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: chunk index k counts 0..N−1.
  - DONE: out_valid=1.
- IDLE → RUN on in_valid && in_ready:
  - latch a.
  - latch b, or ~b when sub=1.
  - set the carry register to cin, or to 1 when sub=1.
  - set k=0.
- In RUN, each edge:
  - computes the chunk-k sum from A[k], B[k] and the carry register.
  - writes it into sum[k*CHUNK +: CHUNK].
  - updates the carry register.
  - increments k.
- On the chunk k=N−1 edge, also:
  - write cout = final carry.
  - write ovf = (carry into bit WIDTH−1) XOR (final carry).
  - move to DONE.
- DONE → IDLE on out_ready (out_valid && out_ready handshake edge).
- sum, cout and ovf hold their values in DONE and IDLE until the next request starts RUN.
- In RUN, sum bits above the current chunk keep their previous value. sum is only meaningful while out_valid=1.
- in_valid during RUN or DONE is ignored. The request must be held by the producer, per valid/ready rules.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (rstn low at an edge), values after that edge:
  - state=IDLE, k=0.
  - sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 (combinational from state).
- Reset is synchronous and has priority over every other transition.
- Reset mid-RUN or in DONE aborts the operation. No out_valid is produced for the aborted request.
- Latency: request handshake at edge E0 → out_valid high after edge EN (N cycles).
- out_valid, sum, cout and ovf are all registered.
- Backpressure: while out_valid && !out_ready, all outputs stay stable and in_ready stays 0.
- After the result handshake edge, in_ready=1 in the next cycle. The earliest next request handshake is at the following edge.
- Peak throughput: one operation per N+2 cycles. There is no overlap of operations.
- N=1: RUN lasts one cycle and behaves as a registered full-width adder with the same handshake.

## Test plan
- WIDTH=32, CHUNK=8, sub=0: a=0xFFFFFFFF, b=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- sub=0: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1. Also a=0x12345678, b=0x11111111, cin=1 → sum=0x2345678A, cout=0, ovf=0.
- sub=1:
  - a=5, b=7, cin=1 (ignored) → sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → sum, cout, ovf and out_valid stable; in_ready=0; a changing in_valid request is ignored. Raise out_ready → IDLE; the next request is accepted one cycle later and its result is correct.
- Reset mid-RUN: assert rstn=0 for one edge when k=2 → out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. The aborted result is never presented. A following request for 0x0000FFFF + 0x00000001 returns 0x00010000.
- CHUNK=32 build: a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1, ovf=0. out_valid 1 cycle after accept.
